dest_packetizer_gen: RTL
========================

// Module: dest_packetizer_gen
// PURPOSE
//  Parametrised bidirectional destination packetizer between a byte/word frame link and N logical channels.
//  RX: first beat of each frame is a header carrying the destination; the remaining beats are forwarded with tid = dest.
//  TX: prepends one header beat (zero-extended tid) to every outgoing packet.
//  New over the fixed 8-bit version: generic widths, destination range check, drop of illegal/empty frames, drop counter.
// PARAMETERS
//  DATA_W    8   tdata width of all four streams, >= TID_W
//  TID_W     3   tid width of packet streams
//  NUM_DEST  8   number of legal destinations, 1..2**TID_W
//  CNT_W     16  width of drop counter
// PORTS
//  aclk              in   1       clock, all logic rising-edge
//  aresetn           in   1       asynchronous active-low reset
//  rx_frame_tvalid/tready/tlast   in/out/in  1  frame input handshake
//  rx_frame_tdata    in   DATA_W  frame input data
//  tx_frame_tvalid/tready/tlast   out/in/out 1  frame output handshake
//  tx_frame_tdata    out  DATA_W  frame output data
//  rx_packet_tvalid/tready/tlast  out/in/out 1  packet output handshake
//  rx_packet_tdata   out  DATA_W  packet payload
//  rx_packet_tid     out  TID_W   destination of current packet
//  tx_packet_tvalid/tready/tlast  in/out/in  1  packet input handshake
//  tx_packet_tdata   in   DATA_W  packet payload
//  tx_packet_tid     in   TID_W   destination, sampled on first beat
//  drop_pulse        out  1       1-cycle pulse per dropped frame
//  drop_cnt          out  CNT_W   saturating count of dropped frames
// BEHAVIOUR
//  Reset: RX FSM=HDR, TX FSM=HDR, tid reg=0, drop_cnt=0, drop_pulse=0; all tvalid/tready low while aresetn=0.
//  Reset mid-packet: partial packet abandoned; next accepted RX beat after release is treated as a header.
//  RX FSM {HDR, PAY, DISC}:
//   HDR: rx_frame_tready=1, rx_packet_tvalid=0. On accepted beat:
//    tlast=1 -> stay HDR, drop (empty frame).
//    tdata >= NUM_DEST (full DATA_W compare, upper bits included) -> DISC, drop.
//    else latch tid=tdata[TID_W-1:0] -> PAY.
//   PAY: combinational pass-through, 0 latency: rx_packet_tvalid=rx_frame_tvalid, rx_frame_tready=rx_packet_tready,
//    tdata/tlast forwarded, rx_packet_tid=latched tid (stable for whole packet). Accepted tlast -> HDR.
//   DISC: rx_frame_tready=1, beats swallowed, rx_packet_tvalid=0; accepted tlast -> HDR.
//  Drop: drop_pulse registered, high exactly the cycle after the dropping header handshake;
//   drop_cnt increments same edge, saturates at 2**CNT_W-1, never wraps.
//  TX FSM {HDR, PAY}:
//   HDR: tx_frame_tvalid=tx_packet_tvalid, tx_frame_tdata=zero-extended tx_packet_tid, tx_frame_tlast=0,
//    tx_packet_tready=0 (beat held). Header handshake -> PAY.
//   PAY: pass-through, tx_packet_tready=tx_frame_tready; accepted tlast -> HDR.
//   Single-beat packet -> 2-beat frame (header, payload w/ tlast). tid changes after header ignored.
//   tx_packet_tid >= NUM_DEST is not checked on TX; sent as-is.
//  AXI rules: no output tvalid depends on its own tready; tvalid once high holds until handshake
//   (header beat holds because tx_packet_* must hold under the same rule).
//  RX and TX paths fully independent; simultaneous activity allowed every cycle.
// STRUCTURE
//  dest_packetizer_pkg: rx_state_t {RX_HDR, RX_PAY, RX_DISC}, tx_state_t {TX_HDR, TX_PAY}.
//  Sub-modules: dest_extract_gen (RX FSM, range check, drop counter) and dest_insert_gen (TX FSM);
//   top instantiates one of each, no glue logic.
// TESTING
//  1 RX frame {0x05,0xA1,0xA2(last)} -> rx_packet 0xA1,0xA2(last), tid=5 both beats; drop_cnt=0.
//  2 NUM_DEST=4, RX frame {0x06,0x11,0x22(last)} then {0x01,0x33(last)} -> first swallowed, drop_pulse once,
//    drop_cnt=1; then 0x33 tid=1 tlast=1.
//  3 RX header-only frame {0x02(last)} -> no rx_packet beat, drop_cnt=1; DATA_W=16 header 0x0102 -> dropped.
//  4 TX packet tid=3 {0xB0,0xB1(last)} with tx_frame_tready random 50% -> frame 0x03,0xB0,0xB1(last),
//    no beat lost/duplicated, tvalid never drops before handshake.
//  5 CNT_W=2, 5 illegal frames -> drop_cnt 1,2,3,3,3.
//  6 Assert aresetn=0 mid RX payload and mid TX payload -> outputs low, cnt=0; after release next frame
//    header decoded correctly on both paths; concurrent RX+TX streaming at full rate, no stalls.

Source files
------------

// File: rtl/dest_packetizer_pkg.sv
// Shared state encodings for the destination packetizer RX and TX paths.
package dest_packetizer_pkg;

  typedef enum logic [1:0] {RX_HDR, RX_PAY, RX_DISC} rx_state_t;
  typedef enum logic       {TX_HDR, TX_PAY}          tx_state_t;

endpackage

// File: rtl/dest_packetizer_gen_if.sv
// Stream interfaces: frame link (no tid) and logical-channel packet stream (with tid).
interface dest_frame_if #(parameter int DATA_W = 8);
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [DATA_W-1:0] tdata;

  modport master (output tvalid, tlast, tdata, input tready);
  modport slave  (input tvalid, tlast, tdata, output tready);
endinterface

interface dest_packet_if #(parameter int DATA_W = 8, parameter int TID_W = 3);
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [DATA_W-1:0] tdata;
  logic [TID_W-1:0]  tid;

  modport master (output tvalid, tlast, tdata, tid, input tready);
  modport slave  (input tvalid, tlast, tdata, tid, output tready);
endinterface

// File: rtl/dest_extract_gen.sv
// RX path: strips the header beat, range-checks the destination, counts dropped frames.
//   state   | meaning
//   RX_HDR  | waiting for header beat, always ready
//   RX_PAY  | zero-latency payload pass-through with latched tid
//   RX_DISC | swallowing the rest of an illegal frame
module dest_extract_gen
  import dest_packetizer_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int TID_W    = 3,
  parameter int NUM_DEST = 8,
  parameter int CNT_W    = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  dest_frame_if.slave      rx_frame,
  dest_packet_if.master    rx_packet,
  output logic             drop_pulse,
  output logic [CNT_W-1:0] drop_cnt
);

  // One extra bit so NUM_DEST == 2**DATA_W does not truncate to zero.
  localparam logic [DATA_W:0] NUM_DEST_EXT = (DATA_W+1)'(NUM_DEST);

  rx_state_t        state, state_nxt;
  logic [TID_W-1:0] tid_q;
  logic             illegal;
  logic             drop;
  logic             tid_load;

  assign illegal = {1'b0, rx_frame.tdata} >= NUM_DEST_EXT;

  always_comb begin
    state_nxt        = state;
    rx_frame.tready  = 1'b0;
    rx_packet.tvalid = 1'b0;
    rx_packet.tdata  = rx_frame.tdata;
    rx_packet.tlast  = rx_frame.tlast;
    rx_packet.tid    = tid_q;
    drop             = 1'b0;
    tid_load         = 1'b0;
    case (state)
      RX_HDR: begin
        rx_frame.tready = aresetn;
        if (rx_frame.tvalid && aresetn) begin
          if (rx_frame.tlast) begin
            drop = 1'b1;
          end else if (illegal) begin
            drop      = 1'b1;
            state_nxt = RX_DISC;
          end else begin
            tid_load  = 1'b1;
            state_nxt = RX_PAY;
          end
        end
      end
      RX_PAY: begin
        rx_packet.tvalid = rx_frame.tvalid & aresetn;
        rx_frame.tready  = rx_packet.tready & aresetn;
        if (rx_frame.tvalid && rx_packet.tready && rx_frame.tlast) state_nxt = RX_HDR;
      end
      RX_DISC: begin
        rx_frame.tready = aresetn;
        if (rx_frame.tvalid && rx_frame.tlast) state_nxt = RX_HDR;
      end
      default: state_nxt = RX_HDR;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= RX_HDR;
      tid_q      <= '0;
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      drop_pulse <= drop;
      if (tid_load) tid_q <= rx_frame.tdata[TID_W-1:0];
      if (drop && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dest_insert_gen.sv
// TX path: prepends a zero-extended tid header beat to every outgoing packet.
//   state  | meaning
//   TX_HDR | presenting header built from the held first packet beat
//   TX_PAY | payload pass-through until tlast
module dest_insert_gen
  import dest_packetizer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int TID_W  = 3
) (
  input  logic          aclk,
  input  logic          aresetn,
  dest_packet_if.slave  tx_packet,
  dest_frame_if.master  tx_frame
);

  tx_state_t state, state_nxt;

  always_comb begin
    state_nxt        = state;
    tx_frame.tvalid  = tx_packet.tvalid & aresetn;
    tx_frame.tdata   = tx_packet.tdata;
    tx_frame.tlast   = tx_packet.tlast;
    tx_packet.tready = 1'b0;
    case (state)
      TX_HDR: begin
        tx_frame.tdata = DATA_W'(tx_packet.tid);
        tx_frame.tlast = 1'b0;
        if (tx_packet.tvalid && tx_frame.tready && aresetn) state_nxt = TX_PAY;
      end
      TX_PAY: begin
        tx_packet.tready = tx_frame.tready & aresetn;
        if (tx_packet.tvalid && tx_frame.tready && tx_packet.tlast) state_nxt = TX_HDR;
      end
      default: state_nxt = TX_HDR;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= TX_HDR;
    else          state <= state_nxt;
  end

endmodule

// File: rtl/dest_packetizer_gen.sv
// Bidirectional destination packetizer: independent RX extractor and TX inserter.
module dest_packetizer_gen #(
  parameter int DATA_W   = 8,
  parameter int TID_W    = 3,
  parameter int NUM_DEST = 8,
  parameter int CNT_W    = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  dest_frame_if.slave      rx_frame,
  dest_frame_if.master     tx_frame,
  dest_packet_if.master    rx_packet,
  dest_packet_if.slave     tx_packet,
  output logic             drop_pulse,
  output logic [CNT_W-1:0] drop_cnt
);

  dest_extract_gen #(
    .DATA_W(DATA_W), .TID_W(TID_W), .NUM_DEST(NUM_DEST), .CNT_W(CNT_W)
  ) u_extract (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .rx_frame   (rx_frame),
    .rx_packet  (rx_packet),
    .drop_pulse (drop_pulse),
    .drop_cnt   (drop_cnt)
  );

  dest_insert_gen #(
    .DATA_W(DATA_W), .TID_W(TID_W)
  ) u_insert (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .tx_packet (tx_packet),
    .tx_frame  (tx_frame)
  );

endmodule
